// File: rtl/net_settle_tracker_if.sv
// Bus bundle for net_settle_tracker: raw driven values in, settled values out.
// glitch_cnt (and CNT_W) exist only when NETSETTLE_GLITCH_CNT_EN is defined.
interface net_settle_tracker_if #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4
`ifdef NETSETTLE_GLITCH_CNT_EN
  ,
  parameter int unsigned CNT_W    = 8
`endif
);

  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_en;
  logic [CHANNELS*WIDTH-1:0] out_data;
  logic [CHANNELS-1:0]       out_valid;
  logic [CHANNELS-1:0]       out_chg;
  logic [CHANNELS-1:0]       busy;
`ifdef NETSETTLE_GLITCH_CNT_EN
  logic [CHANNELS*CNT_W-1:0] glitch_cnt;
`endif

  modport master (
    output in_data,
    output in_en,
    input  out_data,
    input  out_valid,
    input  out_chg,
    input  busy
`ifdef NETSETTLE_GLITCH_CNT_EN
    ,
    input  glitch_cnt
`endif
  );

  modport slave (
    input  in_data,
    input  in_en,
    output out_data,
    output out_valid,
    output out_chg,
    output busy
`ifdef NETSETTLE_GLITCH_CNT_EN
    ,
    output glitch_cnt
`endif
  );

endinterface

// File: rtl/net_settle_tracker.sv
// Multi-channel settle filter: a channel publishes a driven value only after SETTLE equal samples.
// Optional per-channel discarded-transient counters are enabled by NETSETTLE_GLITCH_CNT_EN.
module net_settle_tracker #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SETTLE   = 2
`ifdef NETSETTLE_GLITCH_CNT_EN
  ,
  parameter int unsigned CNT_W    = 8
`endif
) (
  input logic                 clk,
  input logic                 rst_n,
  net_settle_tracker_if.slave bus
);

  localparam int unsigned CW = $clog2(SETTLE + 1);
  localparam logic [CW-1:0] SETTLE_C = CW'(SETTLE);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLING,
    ST_STABLE
  } state_t;

  state_t                    r_state     [CHANNELS];
  state_t                    w_state_nxt [CHANNELS];
  logic [WIDTH-1:0]          r_cand      [CHANNELS];
  logic [WIDTH-1:0]          w_cand_nxt  [CHANNELS];
  logic [CW-1:0]             r_cnt       [CHANNELS];
  logic [CW-1:0]             w_cnt_nxt   [CHANNELS];
  logic [WIDTH-1:0]          w_in        [CHANNELS];
  logic [WIDTH-1:0]          w_pub       [CHANNELS];

  logic [CHANNELS*WIDTH-1:0] r_out_data;
  logic [CHANNELS*WIDTH-1:0] w_out_data_nxt;
  logic [CHANNELS-1:0]       r_out_valid;
  logic [CHANNELS-1:0]       w_out_valid_nxt;
  logic [CHANNELS-1:0]       r_out_chg;
  logic [CHANNELS-1:0]       w_out_chg_nxt;
  logic [CHANNELS-1:0]       r_busy;
  logic [CHANNELS-1:0]       w_busy_nxt;

`ifdef NETSETTLE_GLITCH_CNT_EN
  logic [CHANNELS-1:0]       w_glitch_evt;
  logic [CNT_W-1:0]          r_glitch     [CHANNELS];
  logic [CNT_W-1:0]          w_glitch_nxt [CHANNELS];
  logic [CHANNELS*CNT_W-1:0] w_glitch_flat;
`endif

  // Per-channel views of the flat input and published buses.
  for (genvar g = 0; g < int'(CHANNELS); g++) begin : g_slice
    assign w_in[g]  = bus.in_data[g*WIDTH +: WIDTH];
    assign w_pub[g] = r_out_data[g*WIDTH +: WIDTH];
  end

  // Next-state and next-output computation for every channel.
  always_comb begin : p_next
    w_out_data_nxt  = r_out_data;
    w_out_valid_nxt = r_out_valid;
    w_out_chg_nxt   = '0;
    w_busy_nxt      = r_busy;
`ifdef NETSETTLE_GLITCH_CNT_EN
    w_glitch_evt    = '0;
`endif
    for (int ch = 0; ch < int'(CHANNELS); ch++) begin
      w_state_nxt[ch] = r_state[ch];
      w_cand_nxt[ch]  = r_cand[ch];
      w_cnt_nxt[ch]   = r_cnt[ch];
    end

    for (int ch = 0; ch < int'(CHANNELS); ch++) begin
      if (!bus.in_en[ch]) begin
        w_state_nxt[ch]     = ST_IDLE;
        w_out_valid_nxt[ch] = 1'b0;
        w_busy_nxt[ch]      = 1'b0;
        w_cnt_nxt[ch]       = '0;
      end else if ((r_state[ch] == ST_IDLE) || (w_in[ch] != r_cand[ch])) begin
`ifdef NETSETTLE_GLITCH_CNT_EN
        // With nothing published yet, any abandoned candidate is a transient.
        w_glitch_evt[ch] = (r_state[ch] == ST_SETTLING) &&
                           (!r_out_valid[ch] || (r_cand[ch] != w_pub[ch]));
`endif
        w_cand_nxt[ch] = w_in[ch];
        w_cnt_nxt[ch]  = CW'(1);
        if (SETTLE == 1) begin
          w_out_data_nxt[ch*WIDTH +: WIDTH] = w_in[ch];
          w_out_valid_nxt[ch] = 1'b1;
          w_out_chg_nxt[ch]   = !r_out_valid[ch] || (w_in[ch] != w_pub[ch]);
          w_state_nxt[ch]     = ST_STABLE;
          w_busy_nxt[ch]      = 1'b0;
        end else begin
          w_state_nxt[ch] = ST_SETTLING;
          w_busy_nxt[ch]  = 1'b1;
        end
      end else if (r_state[ch] == ST_SETTLING) begin
        w_cnt_nxt[ch] = r_cnt[ch] + CW'(1);
        if ((r_cnt[ch] + CW'(1)) == SETTLE_C) begin
          w_out_data_nxt[ch*WIDTH +: WIDTH] = w_in[ch];
          w_out_valid_nxt[ch] = 1'b1;
          w_out_chg_nxt[ch]   = !r_out_valid[ch] || (w_in[ch] != w_pub[ch]);
          w_state_nxt[ch]     = ST_STABLE;
          w_busy_nxt[ch]      = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin : p_state
    if (!rst_n) begin
      for (int ch = 0; ch < int'(CHANNELS); ch++) begin
        r_state[ch] <= ST_IDLE;
        r_cand[ch]  <= '0;
        r_cnt[ch]   <= '0;
      end
      r_out_data  <= '0;
      r_out_valid <= '0;
      r_out_chg   <= '0;
      r_busy      <= '0;
    end else begin
      for (int ch = 0; ch < int'(CHANNELS); ch++) begin
        r_state[ch] <= w_state_nxt[ch];
        r_cand[ch]  <= w_cand_nxt[ch];
        r_cnt[ch]   <= w_cnt_nxt[ch];
      end
      r_out_data  <= w_out_data_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_chg   <= w_out_chg_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

`ifdef NETSETTLE_GLITCH_CNT_EN
  // Saturating transient counters, cleared only by reset.
  always_comb begin : p_glitch_next
    for (int ch = 0; ch < int'(CHANNELS); ch++) begin
      w_glitch_nxt[ch] = r_glitch[ch];
      if (w_glitch_evt[ch] && (r_glitch[ch] != {CNT_W{1'b1}})) begin
        w_glitch_nxt[ch] = r_glitch[ch] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin : p_glitch
    for (int ch = 0; ch < int'(CHANNELS); ch++) begin
      if (!rst_n) begin
        r_glitch[ch] <= '0;
      end else begin
        r_glitch[ch] <= w_glitch_nxt[ch];
      end
    end
  end

  always_comb begin : p_glitch_flat
    w_glitch_flat = '0;
    for (int ch = 0; ch < int'(CHANNELS); ch++) begin
      w_glitch_flat[ch*CNT_W +: CNT_W] = r_glitch[ch];
    end
  end

  assign bus.glitch_cnt = w_glitch_flat;
`endif

  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign bus.out_chg   = r_out_chg;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_net_settle_tracker.sv
// Self-checking bench for net_settle_tracker: three configurations checked against a run-length model.
// Glitch-count checks are active only when NETSETTLE_GLITCH_CNT_EN is defined.
module tb_net_settle_tracker;

  localparam int NDUT = 3;
  localparam int SET_S [NDUT] = '{2, 1, 3};
  localparam int NCH   [NDUT] = '{4, 1, 1};
  localparam int CAP   [NDUT] = '{255, 255, 3};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

`ifdef NETSETTLE_GLITCH_CNT_EN
  net_settle_tracker_if #(.WIDTH(8), .CHANNELS(4), .CNT_W(8)) ifa ();
  net_settle_tracker_if #(.WIDTH(8), .CHANNELS(1), .CNT_W(8)) ifb ();
  net_settle_tracker_if #(.WIDTH(8), .CHANNELS(1), .CNT_W(2)) ifc ();
  net_settle_tracker #(.WIDTH(8), .CHANNELS(4), .SETTLE(2), .CNT_W(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  net_settle_tracker #(.WIDTH(8), .CHANNELS(1), .SETTLE(1), .CNT_W(8)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
  net_settle_tracker #(.WIDTH(8), .CHANNELS(1), .SETTLE(3), .CNT_W(2)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));
`else
  net_settle_tracker_if #(.WIDTH(8), .CHANNELS(4)) ifa ();
  net_settle_tracker_if #(.WIDTH(8), .CHANNELS(1)) ifb ();
  net_settle_tracker_if #(.WIDTH(8), .CHANNELS(1)) ifc ();
  net_settle_tracker #(.WIDTH(8), .CHANNELS(4), .SETTLE(2)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  net_settle_tracker #(.WIDTH(8), .CHANNELS(1), .SETTLE(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
  net_settle_tracker #(.WIDTH(8), .CHANNELS(1), .SETTLE(3)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));
`endif

  // Model: length of the current run of equal enabled samples, plus published state.
  int         m_len    [NDUT][4];
  logic [7:0] m_run    [NDUT][4];
  logic [7:0] m_pub    [NDUT][4];
  logic       m_valid  [NDUT][4];
  logic       m_chg    [NDUT][4];
  int         m_glitch [NDUT][4];

  function automatic logic get_in_en(int d, int c);
    case (d)
      0:       return ifa.in_en[c];
      1:       return ifb.in_en[0];
      default: return ifc.in_en[0];
    endcase
  endfunction

  function automatic logic [7:0] get_in_data(int d, int c);
    case (d)
      0:       return ifa.in_data[c*8 +: 8];
      1:       return ifb.in_data;
      default: return ifc.in_data;
    endcase
  endfunction

  // {out_data, out_valid, out_chg, busy}
  function automatic logic [10:0] get_act(int d, int c);
    case (d)
      0:       return {ifa.out_data[c*8 +: 8], ifa.out_valid[c], ifa.out_chg[c], ifa.busy[c]};
      1:       return {ifb.out_data, ifb.out_valid[0], ifb.out_chg[0], ifb.busy[0]};
      default: return {ifc.out_data, ifc.out_valid[0], ifc.out_chg[0], ifc.busy[0]};
    endcase
  endfunction

  function automatic logic [10:0] get_exp(int d, int c);
    logic bsy;
    bsy = (m_len[d][c] >= 1) && (m_len[d][c] < SET_S[d]);
    return {m_pub[d][c], m_valid[d][c], m_chg[d][c], bsy};
  endfunction

`ifdef NETSETTLE_GLITCH_CNT_EN
  function automatic int get_glitch(int d, int c);
    case (d)
      0:       return int'(ifa.glitch_cnt[c*8 +: 8]);
      1:       return int'(ifb.glitch_cnt);
      default: return int'(ifc.glitch_cnt);
    endcase
  endfunction
`endif

  function automatic void model_step();
    for (int d = 0; d < NDUT; d++) begin
      for (int c = 0; c < NCH[d]; c++) begin
        logic [7:0] v;
        logic       en;
        logic       commit;
        v      = get_in_data(d, c);
        en     = get_in_en(d, c);
        commit = 1'b0;
        if (!rst_n) begin
          m_len[d][c] = 0; m_run[d][c] = 8'h00; m_pub[d][c] = 8'h00;
          m_valid[d][c] = 1'b0; m_chg[d][c] = 1'b0; m_glitch[d][c] = 0;
        end else begin
          m_chg[d][c] = 1'b0;
          if (!en) begin
            m_len[d][c]   = 0;
            m_valid[d][c] = 1'b0;
          end else if (m_len[d][c] > 0 && v == m_run[d][c]) begin
            m_len[d][c]++;
            if (m_len[d][c] == SET_S[d]) commit = 1'b1;
          end else begin
            if (m_len[d][c] > 0 && m_len[d][c] < SET_S[d] &&
                (!m_valid[d][c] || m_run[d][c] != m_pub[d][c]) && m_glitch[d][c] < CAP[d])
              m_glitch[d][c]++;
            m_run[d][c] = v;
            m_len[d][c] = 1;
            if (SET_S[d] == 1) commit = 1'b1;
          end
          if (commit) begin
            m_chg[d][c]   = !m_valid[d][c] || (v != m_pub[d][c]);
            m_pub[d][c]   = v;
            m_valid[d][c] = 1'b1;
          end
        end
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_in(int d, int c, logic en, logic [7:0] v);
    case (d)
      0: begin ifa.in_en[c] = en; ifa.in_data[c*8 +: 8] = v; end
      1: begin ifb.in_en[0] = en; ifb.in_data = v; end
      default: begin ifc.in_en[0] = en; ifc.in_data = v; end
    endcase
  endtask

  task automatic idle_all();
    for (int d = 0; d < NDUT; d++)
      for (int c = 0; c < NCH[d]; c++) set_in(d, c, 1'b0, 8'h00);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    idle_all();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int d = 0; d < NDUT; d++)
      for (int c = 0; c < NCH[d]; c++) set_in(d, c, 1'b1, 8'($urandom));
    tick();
    tick();
    for (int d = 0; d < NDUT; d++) begin
      for (int c = 0; c < NCH[d]; c++) begin
        checks++;
        if (get_act(d, c) !== 11'd0) begin
          failures++;
          $display("FAIL reset_out dut%0d ch%0d got=%h exp=000", d, c, get_act(d, c));
        end
`ifdef NETSETTLE_GLITCH_CNT_EN
        checks++;
        if (get_glitch(d, c) !== 0) begin
          failures++;
          $display("FAIL reset_glitch dut%0d ch%0d got=%0d exp=0", d, c, get_glitch(d, c));
        end
`endif
      end
    end
  endtask

  task automatic test_first_publish();
    logic [10:0] exp_seq [3];
    exp_seq[0] = {8'h00, 1'b0, 1'b0, 1'b1};
    exp_seq[1] = {8'h00, 1'b1, 1'b1, 1'b0};
    exp_seq[2] = {8'h00, 1'b1, 1'b0, 1'b0};
    idle_all();
    set_in(0, 0, 1'b1, 8'h00);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (get_act(0, 0) !== exp_seq[i]) begin
        failures++;
        $display("FAIL first_publish edge%0d got=%h exp=%h", i + 1, get_act(0, 0), exp_seq[i]);
      end
      checks++;
      if (get_act(0, 0) !== get_exp(0, 0)) begin
        failures++;
        $display("FAIL first_publish_model edge%0d got=%h exp=%h", i + 1, get_act(0, 0), get_exp(0, 0));
      end
    end
  endtask

  task automatic test_burst();
    int pulses = 0;
    do_reset();
    set_in(0, 0, 1'b1, 8'h00);
    tick();
    set_in(0, 0, 1'b1, 8'h01);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (get_act(0, 0) == {8'h00, 1'b1, 1'b1, 1'b0}) pulses = 99;
      pulses += int'(get_act(0, 0) >> 1 & 11'd1);
      checks++;
      if (get_act(0, 0) !== get_exp(0, 0)) begin
        failures++;
        $display("FAIL burst_model cyc%0d got=%h exp=%h", i, get_act(0, 0), get_exp(0, 0));
      end
      checks++;
      if (get_act(0, 0) >> 2 == {8'h00, 1'b1}) begin
        failures++;
        $display("FAIL burst_transient_published cyc%0d got=%h exp=not_00_valid", i, get_act(0, 0));
      end
    end
    checks++;
    if (pulses != 1 || get_act(0, 0) !== {8'h01, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL burst_final pulses=%0d got=%h exp_pulses=1 exp=%h", pulses, get_act(0, 0), {8'h01, 3'b100});
    end
`ifdef NETSETTLE_GLITCH_CNT_EN
    checks++;
    if (get_glitch(0, 0) !== 1) begin
      failures++;
      $display("FAIL burst_glitch got=%0d exp=1", get_glitch(0, 0));
    end
`endif
  endtask

  task automatic test_settle1();
    for (int i = 0; i < 40; i++) begin
      logic       en;
      logic [7:0] v;
      en = ($urandom_range(0, 7) != 0);
      v  = 8'($urandom_range(0, 3));
      set_in(1, 0, en, v);
      tick();
      checks++;
      if (get_act(1, 0) !== get_exp(1, 0)) begin
        failures++;
        $display("FAIL settle1_model cyc%0d got=%h exp=%h", i, get_act(1, 0), get_exp(1, 0));
      end
      checks++;
      if (get_act(1, 0) & 11'd1 || (en && (get_act(1, 0) >> 2) !== {v, 1'b1})) begin
        failures++;
        $display("FAIL settle1_follow cyc%0d got=%h exp_data=%h en=%0d busy=0", i, get_act(1, 0), v, en);
      end
    end
  endtask

  task automatic test_return();
    logic [7:0] seq [4];
    seq = '{8'h07, 8'h05, 8'h05, 8'h05};
    do_reset();
    set_in(0, 1, 1'b1, 8'h05);
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      set_in(0, 1, 1'b1, seq[i]);
      tick();
      checks++;
      if ((get_act(0, 1) >> 1) !== {8'h05, 1'b1, 1'b0} || get_act(0, 1) !== get_exp(0, 1)) begin
        failures++;
        $display("FAIL return_hold cyc%0d got=%h exp=%h", i, get_act(0, 1), get_exp(0, 1));
      end
    end
`ifdef NETSETTLE_GLITCH_CNT_EN
    checks++;
    if (get_glitch(0, 1) !== 1) begin
      failures++;
      $display("FAIL return_glitch got=%0d exp=1", get_glitch(0, 1));
    end
`endif
  endtask

  task automatic test_independent();
    logic [7:0]  v_old [4];
    logic [7:0]  v_new [4];
    logic [10:0] exp;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      v_old[c] = 8'($urandom);
      v_new[c] = v_old[c] ^ 8'hA5;
      set_in(0, c, 1'b1, v_old[c]);
    end
    tick(); tick(); tick();
    for (int c = 0; c < 4; c++) set_in(0, c, 1'b1, v_new[c]);
    tick();
    set_in(0, 2, 1'b0, v_new[2]);
    tick();
    tick();
    for (int c = 0; c < 4; c++) begin
      exp = (c == 2) ? {v_old[c], 3'b000} : {v_new[c], 3'b100};
      checks++;
      if (get_act(0, c) !== exp || get_act(0, c) !== get_exp(0, c)) begin
        failures++;
        $display("FAIL independent ch%0d got=%h exp=%h model=%h", c, get_act(0, c), exp, get_exp(0, c));
      end
    end
  endtask

  task automatic test_saturate_and_reset();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      set_in(2, 0, 1'b1, (i % 2 != 0) ? 8'h20 : 8'h10);
      tick();
      checks++;
      if (get_act(2, 0) !== get_exp(2, 0)) begin
        failures++;
        $display("FAIL sat_model cyc%0d got=%h exp=%h", i, get_act(2, 0), get_exp(2, 0));
      end
    end
`ifdef NETSETTLE_GLITCH_CNT_EN
    checks++;
    if (get_glitch(2, 0) !== 3) begin
      failures++;
      $display("FAIL sat_glitch got=%0d exp=3", get_glitch(2, 0));
    end
`endif
    set_in(2, 0, 1'b1, 8'h30);
    tick();
    checks++;
    if ((get_act(2, 0) & 11'd1) !== 11'd1) begin
      failures++;
      $display("FAIL midsettle_busy got=%h exp_busy=1", get_act(2, 0));
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if (get_act(2, 0) !== 11'd0) begin
      failures++;
      $display("FAIL midsettle_reset got=%h exp=000", get_act(2, 0));
    end
`ifdef NETSETTLE_GLITCH_CNT_EN
    checks++;
    if (get_glitch(2, 0) !== 0) begin
      failures++;
      $display("FAIL midsettle_reset_glitch got=%0d exp=0", get_glitch(2, 0));
    end
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      rst_n = ($urandom_range(0, 63) != 0);
      for (int d = 0; d < NDUT; d++)
        for (int c = 0; c < NCH[d]; c++)
          set_in(d, c, ($urandom_range(0, 9) != 0), 8'($urandom_range(0, 3)) << (c * 2));
      tick();
      for (int d = 0; d < NDUT; d++) begin
        for (int c = 0; c < NCH[d]; c++) begin
          checks++;
          if (get_act(d, c) !== get_exp(d, c)) begin
            failures++;
            $display("FAIL random cyc%0d dut%0d ch%0d got=%h exp=%h", i, d, c, get_act(d, c), get_exp(d, c));
          end
`ifdef NETSETTLE_GLITCH_CNT_EN
          checks++;
          if (get_glitch(d, c) !== m_glitch[d][c]) begin
            failures++;
            $display("FAIL random_glitch cyc%0d dut%0d ch%0d got=%0d exp=%0d", i, d, c, get_glitch(d, c), m_glitch[d][c]);
          end
`endif
        end
      end
    end
  endtask

  initial begin
    idle_all();
    test_reset();
    test_first_publish();
    test_burst();
    test_settle1();
    test_return();
    test_independent();
    test_saturate_and_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
